// File: rtl/mem_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_seq_pkg : shared types and error codes for byte_mem_sequencer     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package mem_seq_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Codes 1 and 2 belong to the CPU's older fault sources.
  localparam logic [3:0] ERR_NONE     = 4'd0;
  localparam logic [3:0] ERR_MISALIGN = 4'd3;
  localparam logic [3:0] ERR_RANGE    = 4'd4;
  localparam logic [3:0] ERR_SIZE     = 4'd5;

  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_mem_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | byte_mem_sequencer_if : requester, response and byte-RAM signals      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface byte_mem_sequencer_if #(
  parameter int ADDR_W = 24
);
  logic              p0_valid;
  logic              p0_ready;
  logic              p0_we;
  logic [31:0]       p0_addr;
  logic [1:0]        p0_size;
  logic              p0_unsigned;
  logic [31:0]       p0_wdata;

  logic              p1_valid;
  logic              p1_ready;
  logic              p1_we;
  logic [31:0]       p1_addr;
  logic [1:0]        p1_size;
  logic              p1_unsigned;
  logic [31:0]       p1_wdata;

  logic              rsp_done;
  logic              rsp_id;
  logic [31:0]       rsp_rdata;
  logic [3:0]        rsp_err;
  logic              busy;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  // Master is the system side: both requesters plus the RAM.
  modport master (
    output p0_valid, p0_we, p0_addr, p0_size, p0_unsigned, p0_wdata,
    input  p0_ready,
    output p1_valid, p1_we, p1_addr, p1_size, p1_unsigned, p1_wdata,
    input  p1_ready,
    input  rsp_done, rsp_id, rsp_rdata, rsp_err, busy,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_size, p0_unsigned, p0_wdata,
    output p0_ready,
    input  p1_valid, p1_we, p1_addr, p1_size, p1_unsigned, p1_wdata,
    output p1_ready,
    output rsp_done, rsp_id, rsp_rdata, rsp_err, busy,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/byte_mem_sequencer_load_extend.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | load_extend : sign/zero extension of assembled little-endian bytes    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module load_extend
  import mem_seq_pkg::*;
(
  input  logic [31:0] i_bytes,
  input  size_t       i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_bytes;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_bytes[7]  & ~i_unsigned}}, i_bytes[7:0]};
      SZ_HALF: o_data = {{16{i_bytes[15] & ~i_unsigned}}, i_bytes[15:0]};
      default: o_data = i_bytes;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/byte_mem_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | byte_mem_sequencer : arbitrates two requesters onto a byte-wide RAM   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module byte_mem_sequencer #(
  parameter int ADDR_W = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  byte_mem_sequencer_if.slave  bus
);
  import mem_seq_pkg::*;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last_grant;
  logic                r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_we;
  logic                r_uns;
  logic [31:0]         r_wdata;
  logic [3:0]          r_err;
  logic [1:0]          r_beat;
  logic [31:0]         r_bytes;
  logic [ADDR_W-1:0]   r_mem_addr;

  logic                w_grant0;
  logic                w_grant1;
  logic                w_accept;
  logic                w_we;
  logic [31:0]         w_addr;
  logic [1:0]          w_size;
  logic                w_uns;
  logic [31:0]         w_wdata;
  logic [32:0]         w_span;
  logic [3:0]          w_err;
  logic [1:0]          w_last_idx;
  logic                w_last_beat;
  logic [ADDR_W-1:0]   w_beat_addr;
  logic [1:0]          w_cap_lane;
  logic                w_cap_en;
  logic                w_issue;
  logic                w_resp;
  logic [31:0]         w_ext;

  // On a tie the port that did not win last time is granted.
  assign w_grant0 = bus.p0_valid && (!bus.p1_valid || r_last_grant);
  assign w_grant1 = bus.p1_valid && (!bus.p0_valid || !r_last_grant);
  assign w_accept = (r_state == S_IDLE) && !reset && (w_grant0 || w_grant1);

  assign w_we    = w_grant1 ? bus.p1_we       : bus.p0_we;
  assign w_addr  = w_grant1 ? bus.p1_addr     : bus.p0_addr;
  assign w_size  = w_grant1 ? bus.p1_size     : bus.p0_size;
  assign w_uns   = w_grant1 ? bus.p1_unsigned : bus.p0_unsigned;
  assign w_wdata = w_grant1 ? bus.p1_wdata    : bus.p0_wdata;

  assign w_span = {1'b0, w_addr} + {30'd0, size_bytes(w_size)} - 33'd1;

  always_comb begin
    w_err = ERR_NONE;
    if (w_size == SZ_ILLEGAL)
      w_err = ERR_SIZE;
    else if ((w_size == SZ_HALF && w_addr[0]) || (w_size == SZ_WORD && w_addr[1:0] != 2'b00))
      w_err = ERR_MISALIGN;
    else if (|w_span[32:ADDR_W])
      w_err = ERR_RANGE;
  end

  assign w_issue     = (r_state == S_ISSUE);
  assign w_resp      = (r_state == S_RESP);
  assign w_last_idx  = 2'(size_bytes(r_size) - 3'd1);
  assign w_last_beat = (r_beat == w_last_idx);
  assign w_beat_addr = r_addr + ADDR_W'(r_beat);

  // RAM read data trails the address by one cycle, so lanes land one beat late.
  assign w_cap_lane = (r_state == S_DRAIN) ? r_beat : r_beat - 2'd1;
  assign w_cap_en   = !r_we && ((w_issue && r_beat != 2'd0) || r_state == S_DRAIN);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = (w_err != ERR_NONE) ? S_RESP : S_ISSUE;
      S_ISSUE: if (w_last_beat) w_state_next = r_we ? S_RESP : S_DRAIN;
      S_DRAIN: w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_addr       <= '0;
      r_size       <= 2'b00;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_wdata      <= 32'd0;
      r_err        <= ERR_NONE;
      r_beat       <= 2'd0;
      r_bytes      <= 32'd0;
      r_mem_addr   <= '0;
    end else begin
      if (w_accept) begin
        r_id         <= w_grant1;
        r_last_grant <= w_grant1;
        r_addr       <= w_addr[ADDR_W-1:0];
        r_size       <= w_size;
        r_we         <= w_we;
        r_uns        <= w_uns;
        r_wdata      <= w_wdata;
        r_err        <= w_err;
        r_beat       <= 2'd0;
        r_bytes      <= 32'd0;
      end
      if (w_issue) begin
        r_mem_addr <= w_beat_addr;
        if (!w_last_beat) r_beat <= r_beat + 2'd1;
      end
      if (w_cap_en) r_bytes[{w_cap_lane, 3'b000} +: 8] <= bus.mem_rdata;
    end
  end

  load_extend u_load_extend (
    .i_bytes    (r_bytes),
    .i_size     (size_t'(r_size)),
    .i_unsigned (r_uns),
    .o_data     (w_ext)
  );

  assign bus.p0_ready  = w_accept && w_grant0;
  assign bus.p1_ready  = w_accept && w_grant1;
  assign bus.rsp_done  = w_resp;
  assign bus.rsp_id    = w_resp && r_id;
  assign bus.rsp_err   = w_resp ? r_err : ERR_NONE;
  assign bus.rsp_rdata = w_resp ? w_ext : 32'd0;
  assign bus.busy      = (r_state != S_IDLE);

  // Reset must stop the write of the beat in flight.
  assign bus.mem_we    = w_issue && r_we && !reset;
  assign bus.mem_addr  = w_issue ? w_beat_addr : r_mem_addr;
  assign bus.mem_wdata = (w_issue && r_we) ? r_wdata[{r_beat, 3'b000} +: 8] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_byte_mem_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_byte_mem_sequencer : directed + random checks against a RAM model  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_byte_mem_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   we_cycles = 0;

  logic [7:0] ram [0:511];
  logic [7:0] mdl [0:511];

  always #5 clk = ~clk;

  byte_mem_sequencer_if #(.ADDR_W(24)) bus ();

  byte_mem_sequencer #(.ADDR_W(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[8:0]] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr[8:0]];
  end

  always @(negedge clk) if (bus.mem_we) we_cycles <= we_cycles + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b01) ? 2 : (s == 2'b10) ? 4 : 1;
  endfunction

  function automatic logic [3:0] exp_err(input logic [31:0] a, input logic [1:0] s);
    longint n = longint'(nbytes(s));
    if (s == 2'b11) return 4'd5;
    if (longint'(a) % n != 0) return 4'd3;
    if (longint'(a) + n - 1 >= (longint'(1) << 24)) return 4'd4;
    return 4'd0;
  endfunction

  function automatic logic [31:0] model_read(input int a, input logic [1:0] s, input bit u);
    longint v = 0;
    int n = nbytes(s);
    for (int i = 0; i < n; i++) v += longint'(mdl[a + i]) << (8 * i);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic rdy(input bit port);
    return port ? bus.p1_ready : bus.p0_ready;
  endfunction

  task automatic drive(input bit port, input bit v, input bit we, input logic [31:0] a,
                       input logic [1:0] s, input bit u, input logic [31:0] wd);
    if (!port) begin
      bus.p0_valid = v; bus.p0_we = we; bus.p0_addr = a;
      bus.p0_size = s; bus.p0_unsigned = u; bus.p0_wdata = wd;
    end else begin
      bus.p1_valid = v; bus.p1_we = we; bus.p1_addr = a;
      bus.p1_size = s; bus.p1_unsigned = u; bus.p1_wdata = wd;
    end
  endtask

  task automatic wait_ready(input bit port, input string tag);
    int c = 0;
    #1;
    while (rdy(port) == 1'b0 && c < 40) begin @(negedge clk); #1; c++; end
    chk({tag, "_rdy"}, 32'(rdy(port)), 32'd1);
  endtask

  task automatic wait_rsp(input bit id, input logic [3:0] eerr, input logic [31:0] erd,
                          input int elat, input string tag);
    int lat = 0;
    do begin @(negedge clk); #1; lat++; end while (!bus.rsp_done && lat < 30);
    chk({tag, "_done"}, 32'(bus.rsp_done), 32'd1);
    chk({tag, "_lat"},  32'(lat), 32'(elat));
    chk({tag, "_id"},   32'(bus.rsp_id), 32'(id));
    chk({tag, "_err"},  32'(bus.rsp_err), 32'(eerr));
    chk({tag, "_data"}, bus.rsp_rdata, erd);
  endtask

  task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                        input logic [1:0] sz, input bit uns, input logic [31:0] wd,
                        input string tag);
    logic [3:0]  eerr;
    logic [31:0] erd;
    int n, elat, we0;
    eerr = exp_err(addr, sz);
    n    = nbytes(sz);
    erd  = (eerr == 4'd0 && !we) ? model_read(int'(addr), sz, uns) : 32'd0;
    elat = (eerr != 4'd0) ? 1 : (we ? n + 1 : n + 2);
    @(negedge clk);
    drive(port, 1'b1, we, addr, sz, uns, wd);
    wait_ready(port, tag);
    we0 = we_cycles;
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
    wait_rsp(port, eerr, erd, elat, tag);
    chk({tag, "_wecnt"}, 32'(we_cycles - we0), 32'((eerr == 4'd0 && we) ? n : 0));
    if (eerr == 4'd0 && we)
      for (int i = 0; i < n; i++) mdl[int'(addr) + i] = wd[8 * i +: 8];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy0"},  32'(bus.p0_ready), 32'd0);
    chk({tag, "_rdy1"},  32'(bus.p1_ready), 32'd0);
    chk({tag, "_done"},  32'(bus.rsp_done), 32'd0);
    chk({tag, "_id"},    32'(bus.rsp_id), 32'd0);
    chk({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
    chk({tag, "_err"},   32'(bus.rsp_err), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_maddr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mwe"},   32'(bus.mem_we), 32'd0);
    chk({tag, "_mwd"},   32'(bus.mem_wdata), 32'd0);
  endtask

  initial begin
    logic [31:0] arb_addr [2][2];
    logic [1:0]  arb_size [2][2];
    bit          arb_uns  [2][2];
    int          pi [2];
    logic [31:0] a, w;
    logic [1:0]  s;
    bit          u, g;
    int          c, dones;

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_all_zero("rst");
    reset = 1'b0;

    for (int i = 0; i < 512; i += 4)
      do_txn(1'($urandom_range(0, 1)), 1'b1, 32'(i), 2'b10, 1'b0, $urandom, "fill");

    // Word store/load round trip on the data port
    do_txn(1'b1, 1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF, "st_word");
    chk("ram100", 32'(ram[9'h100]), 32'hEF);
    chk("ram101", 32'(ram[9'h101]), 32'hBE);
    chk("ram102", 32'(ram[9'h102]), 32'hAD);
    chk("ram103", 32'(ram[9'h103]), 32'hDE);
    do_txn(1'b1, 1'b0, 32'h100, 2'b10, 1'b0, 32'd0, "ld_word");

    // Sign and zero extension
    do_txn(1'b1, 1'b1, 32'h20, 2'b00, 1'b0, 32'h80, "st_b20");
    do_txn(1'b1, 1'b1, 32'h21, 2'b00, 1'b0, 32'h7F, "st_b21");
    do_txn(1'b1, 1'b0, 32'h20, 2'b00, 1'b0, 32'd0, "ld_sbyte");
    chk("ld_sbyte_lit", model_read(32'h20, 2'b00, 1'b0), 32'hFFFFFF80);
    do_txn(1'b1, 1'b0, 32'h20, 2'b00, 1'b1, 32'd0, "ld_ubyte");
    do_txn(1'b0, 1'b0, 32'h20, 2'b01, 1'b0, 32'd0, "ld_shalf");

    // Error paths
    do_txn(1'b1, 1'b0, 32'h102,       2'b10, 1'b0, 32'd0, "err_mis_w");
    do_txn(1'b1, 1'b1, 32'h00FFFFFF,  2'b01, 1'b0, 32'h1234, "err_mis_h");
    do_txn(1'b0, 1'b0, 32'h0100_0000, 2'b00, 1'b0, 32'd0, "err_range");
    do_txn(1'b1, 1'b1, 32'h10,        2'b11, 1'b0, 32'h55, "err_size");

    // Arbitration with both ports continuously valid
    arb_addr[0][0] = 32'h40; arb_size[0][0] = 2'b10; arb_uns[0][0] = 1'b0;
    arb_addr[0][1] = 32'h48; arb_size[0][1] = 2'b00; arb_uns[0][1] = 1'b0;
    arb_addr[1][0] = 32'h60; arb_size[1][0] = 2'b01; arb_uns[1][0] = 1'b1;
    arb_addr[1][1] = 32'h64; arb_size[1][1] = 2'b10; arb_uns[1][1] = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, arb_addr[0][0], arb_size[0][0], arb_uns[0][0], 32'd0);
    drive(1'b1, 1'b1, 1'b0, arb_addr[1][0], arb_size[1][0], arb_uns[1][0], 32'd0);
    pi[0] = 1; pi[1] = 1;
    for (int i = 0; i < 4; i++) begin
      c = 0;
      #1;
      while (!bus.p0_ready && !bus.p1_ready && c < 40) begin @(negedge clk); #1; c++; end
      chk($sformatf("arb%0d_any", i), 32'(bus.p0_ready | bus.p1_ready), 32'd1);
      g = bus.p1_ready;
      chk($sformatf("arb%0d_grant", i), 32'(g), 32'(i % 2));
      a = g ? bus.p1_addr : bus.p0_addr;
      s = g ? bus.p1_size : bus.p0_size;
      u = g ? bus.p1_unsigned : bus.p0_unsigned;
      @(posedge clk); #1;
      if (pi[g] < 2) begin
        drive(g, 1'b1, 1'b0, arb_addr[g][pi[g]], arb_size[g][pi[g]], arb_uns[g][pi[g]], 32'd0);
        pi[g]++;
      end else begin
        drive(g, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
      end
      wait_rsp(g, 4'd0, model_read(int'(a), s, u), nbytes(s) + 2, $sformatf("arb%0d", i));
    end

    // Reset during beat 2 of a word store
    do_txn(1'b0, 1'b1, 32'h180, 2'b10, 1'b0, 32'h11223344, "pre_rst");
    w = $urandom;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'h180, 2'b10, 1'b0, w);
    wait_ready(1'b1, "rst_st");
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_beat2_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk); #1;
    chk_all_zero("rst_mid");
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_done) dones++;
    end
    chk("rst_no_done", 32'(dones), 32'd0);
    mdl[9'h180] = w[7:0];
    mdl[9'h181] = w[15:8];
    chk("rst_ram180", 32'(ram[9'h180]), 32'(w[7:0]));
    chk("rst_ram181", 32'(ram[9'h181]), 32'(w[15:8]));
    chk("rst_ram182", 32'(ram[9'h182]), 32'h22);
    chk("rst_ram183", 32'(ram[9'h183]), 32'h11);
    do_txn(1'b0, 1'b0, 32'h180, 2'b10, 1'b0, 32'd0, "post_rst_ld");

    // Randomized mix against the model
    for (int i = 0; i < 30; i++) begin
      s = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) s = 2'b11;
      a = 32'h80 + 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(s)) - 32'd1);
      if ($urandom_range(0, 9) == 0) a = 32'h0100_0000 + 32'($urandom_range(0, 255));
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, s,
             1'($urandom_range(0, 1)), $urandom, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
